// File: rtl/ui_pkg.sv
// Shared UI definitions: flasher FSM encoding, system clock rate and timing helpers.
package ui_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } flash_state_t;

  localparam int CLK_HZ = 100_000_000;

  function automatic int ms_to_cycles(input int ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

  // Counter holds at most max(on,off)-1, so clog2(max) bits suffice; keep at least 1 bit.
  function automatic int timer_width(input int on_cycles, input int off_cycles);
    int m;
    m = (on_cycles > off_cycles) ? on_cycles : off_cycles;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter: counts to zero and holds there; done is high while the count is zero.
module cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/event_flasher.sv
// Turns single-cycle event pulses into one fixed-length flash each, queueing events
// that arrive mid-flash in a saturating counter with a sticky overflow flag.
module event_flasher
  import ui_pkg::*;
#(
  parameter int ON_CYCLES  = ms_to_cycles(50),
  parameter int OFF_CYCLES = ms_to_cycles(50),
  parameter int PEND_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pulse_in,
  input  logic              clear,
  output logic              led_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int TW = timer_width(ON_CYCLES, OFF_CYCLES);
  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);

  flash_state_t  state;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_done;
  logic          start;
  logic          inc;

  cycle_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // A flash may begin from IDLE any time, or straight out of an expiring gap.
  assign start = !clear && (pending != '0) &&
                 ((state == IDLE) || ((state == GAP) && tmr_done));
  assign inc   = pulse_in && !clear;

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (clear) begin
      tmr_load = 1'b1;
    end else if (start) begin
      tmr_load = 1'b1;
      tmr_val  = ON_LOAD;
    end else if ((state == ON) && tmr_done) begin
      tmr_load = 1'b1;
      tmr_val  = OFF_LOAD;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      led_out  <= 1'b0;
      pending  <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      state    <= IDLE;
      led_out  <= 1'b0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state   <= ON;
          led_out <= 1'b1;
        end
        ON: if (tmr_done) begin
          state   <= GAP;
          led_out <= 1'b0;
        end
        GAP: if (start) begin
          state   <= ON;
          led_out <= 1'b1;
        end else if (tmr_done) begin
          state   <= IDLE;
        end
        default: begin
          state   <= IDLE;
          led_out <= 1'b0;
        end
      endcase

      // A simultaneous increment and start cancel out, which also covers saturation.
      if (inc && !start) begin
        if (pending == '1) overflow <= 1'b1;
        else               pending  <= pending + 1'b1;
      end else if (start && !inc) begin
        pending <= pending - 1'b1;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
